reg_read_port: RTL and testbench
================================

REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count; ADDR_W = 4 is derived as log2(NUM_REGS).
REQ-003 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have R0..R15  input  32 each  register bank outputs.
REQ-006 SHALL have enable  input  16  one-hot write enable driven to the bank.
REQ-007 SHALL have load_data  input  32  write data driven to the bank.
REQ-008 SHALL have req_valid  input  1  read request present.
REQ-009 SHALL have req_ready  output  1  request accepted when high together with req_valid.
REQ-010 SHALL have src_a, src_b  input  4 each  source register indices.
REQ-011 SHALL have rsp_valid  output  1  operands valid.
REQ-012 SHALL have rsp_ready  input  1  consumer takes operands.
REQ-013 SHALL have op_a, op_b  output  32 each  registered operands.
REQ-014 SHALL have rd_count  output  16  number of accepted requests.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid and req_ready are both high.
REQ-016 SHALL use a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 SHALL make these transitions: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on rsp_ready with a simultaneous accept.
REQ-018 SHALL drive req_ready = !rsp_valid || rsp_ready (combinational), allowing back-to-back throughput of one request per cycle.
REQ-019 SHALL capture op_a = R[src_a] and op_b = R[src_b] on the accept edge, giving a latency of one cycle from accept to rsp_valid.
REQ-020 SHALL hold op_a, op_b and rsp_valid stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL treat src_a == src_b as legal, returning identical op_a and op_b.
REQ-022 SHALL increment rd_count by 1 on each accept, wrapping from 16'hFFFF to 0.
REQ-023 SHALL ignore req_valid when req_ready=0: no capture and no count.

Reset
REQ-024 SHALL on rst_n low immediately set the FSM to EMPTY and force rsp_valid=0, op_a=0, op_b=0 and rd_count=0, independent of clk.
REQ-025 SHALL discard any held response when reset is asserted mid-transfer; no replay after reset.
REQ-026 SHALL accept the first request on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL use the macro REG_READ_BYPASS_EN to control write forwarding.
REQ-028 With REG_READ_BYPASS_EN defined, SHALL capture load_data instead of R[src_x] on the accept edge when enable is exactly one-hot with bit src_x set; each operand is forwarded independently.
REQ-029 With REG_READ_BYPASS_EN defined, SHALL apply no forwarding when enable is zero or multi-hot.
REQ-030 Without REG_READ_BYPASS_EN, SHALL always capture R[src_x], and enable and load_data SHALL be unused.

Structure
REQ-031 SHALL take DATA_W, ADDR_W, NUM_REGS and the reg_idx_t (4-bit) typedef from shared package reg_bank_pkg.
REQ-032 SHALL implement the 16:1 selection in sub-module reg_src_mux, instantiated twice (operands a and b).

Verification
REQ-033 Bench SHALL check: R5=32'hDEADBEEF, R9=32'h12345678; accept src_a=5, src_b=9 -> next cycle rsp_valid=1, op_a=DEADBEEF, op_b=12345678, rd_count=1.
REQ-034 Bench SHALL check: rsp_ready=0 for 3 cycles after a response, with R5 changed -> op_a, op_b unchanged, req_ready=0, rd_count unchanged.
REQ-035 Bench SHALL check: rsp_ready=1 and req_valid=1 for 4 cycles, src_a=0..3 -> one response per cycle in order, rd_count=4.
REQ-036 Bench SHALL check (bypass build): enable=16'h0008, load_data=32'hA5A5A5A5, R3 old=0, accept src_a=3 -> op_a=A5A5A5A5; with enable=16'h0018 -> op_a=R3.
REQ-037 Bench SHALL check: rst_n low mid-FULL -> rsp_valid=0, op_a=0, rd_count=0 asynchronously; preset rd_count=16'hFFFF plus one accept -> 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared register-bank types and sizes for the operand read port.
package reg_bank_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
  localparam int unsigned CNT_W    = 16;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rd_state_t;

  // True when exactly one bit of the write-enable vector is set.
  function automatic logic is_one_hot(logic [NUM_REGS-1:0] v);
    return (v != '0) && ((v & (v - NUM_REGS'(1))) == '0);
  endfunction

endpackage

// File: rtl/reg_src_mux.sv
// One source-operand selector: picks a single register out of the bank.
module reg_src_mux
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = reg_bank_pkg::DATA_W,
  parameter int unsigned NUM_REGS = reg_bank_pkg::NUM_REGS
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  reg_idx_t          sel,
  output logic [DATA_W-1:0] data_c
);

  assign data_c = regs[sel];

endmodule

// File: rtl/reg_read_port.sv
// Two-operand register read port with a one-deep valid/ready response stage.
// Define REG_READ_BYPASS_EN to forward a same-cycle one-hot bank write into the operands.
module reg_read_port
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = reg_bank_pkg::DATA_W,
  parameter int unsigned NUM_REGS = reg_bank_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   R0,
  input  logic [DATA_W-1:0]   R1,
  input  logic [DATA_W-1:0]   R2,
  input  logic [DATA_W-1:0]   R3,
  input  logic [DATA_W-1:0]   R4,
  input  logic [DATA_W-1:0]   R5,
  input  logic [DATA_W-1:0]   R6,
  input  logic [DATA_W-1:0]   R7,
  input  logic [DATA_W-1:0]   R8,
  input  logic [DATA_W-1:0]   R9,
  input  logic [DATA_W-1:0]   R10,
  input  logic [DATA_W-1:0]   R11,
  input  logic [DATA_W-1:0]   R12,
  input  logic [DATA_W-1:0]   R13,
  input  logic [DATA_W-1:0]   R14,
  input  logic [DATA_W-1:0]   R15,
  input  logic [NUM_REGS-1:0] enable,
  input  logic [DATA_W-1:0]   load_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  reg_idx_t            src_a,
  input  reg_idx_t            src_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [CNT_W-1:0]    rd_count
);

  logic [DATA_W-1:0] bank [NUM_REGS];
  logic [DATA_W-1:0] mux_a, mux_b;
  logic [DATA_W-1:0] cap_a, cap_b;
  rd_state_t         state, next_state;
  logic              accept;

  assign bank[0]  = R0;
  assign bank[1]  = R1;
  assign bank[2]  = R2;
  assign bank[3]  = R3;
  assign bank[4]  = R4;
  assign bank[5]  = R5;
  assign bank[6]  = R6;
  assign bank[7]  = R7;
  assign bank[8]  = R8;
  assign bank[9]  = R9;
  assign bank[10] = R10;
  assign bank[11] = R11;
  assign bank[12] = R12;
  assign bank[13] = R13;
  assign bank[14] = R14;
  assign bank[15] = R15;

  reg_src_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_mux_a (
    .regs   (bank),
    .sel    (src_a),
    .data_c (mux_a)
  );

  reg_src_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_mux_b (
    .regs   (bank),
    .sel    (src_b),
    .data_c (mux_b)
  );

`ifdef REG_READ_BYPASS_EN
  // A write landing this cycle wins over the stale bank value, per operand.
  logic wr_one_hot;
  assign wr_one_hot = is_one_hot(enable);
  assign cap_a      = (wr_one_hot && enable[src_a]) ? load_data : mux_a;
  assign cap_b      = (wr_one_hot && enable[src_b]) ? load_data : mux_b;
`else
  logic unused_bypass;
  assign unused_bypass = ^{enable, load_data};
  assign cap_a         = mux_a;
  assign cap_b         = mux_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= next_state;
  end

  // Handshake and occupancy; a slot being drained can be refilled in the same cycle.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    case (state)
      EMPTY: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (accept) next_state = FULL;
      end
      FULL: begin
        req_ready = rsp_ready;
        accept    = req_valid && rsp_ready;
        if (rsp_ready && !accept) next_state = EMPTY;
      end
      default: next_state = EMPTY;
    endcase
  end

  assign rsp_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      rd_count <= '0;
    end else if (accept) begin
      op_a     <= cap_a;
      op_b     <= cap_b;
      rd_count <= rd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: directed table, corner sequences, random scoreboard.
module tb_reg_read_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rb [16];
  logic [15:0] enable;
  logic [31:0] load_data;
  logic        req_valid, req_ready;
  logic [3:0]  src_a, src_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] op_a, op_b;
  logic [15:0] rd_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_read_port dut (
    .clk(clk), .rst_n(rst_n),
    .R0(rb[0]), .R1(rb[1]), .R2(rb[2]), .R3(rb[3]),
    .R4(rb[4]), .R5(rb[5]), .R6(rb[6]), .R7(rb[7]),
    .R8(rb[8]), .R9(rb[9]), .R10(rb[10]), .R11(rb[11]),
    .R12(rb[12]), .R13(rb[13]), .R14(rb[14]), .R15(rb[15]),
    .enable(enable), .load_data(load_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .src_a(src_a), .src_b(src_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .op_a(op_a), .op_b(op_b), .rd_count(rd_count)
  );

  typedef struct {
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [31:0] va;
    logic [31:0] vb;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } rsp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operand the specification says should be captured for a given source index.
  function automatic logic [31:0] ref_op(input logic [3:0] s);
`ifdef REG_READ_BYPASS_EN
    if ($countones(enable) == 1 && enable[s]) return load_data;
`endif
    return rb[s];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    enable    = '0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t  tbl [5];
  rsp_t  sb_q [$];
  rsp_t  r;
  logic [15:0] cnt;
  logic  acc;

  initial begin
    for (int i = 0; i < 16; i++) rb[i] = 32'(i) * 32'h0101_0101;
    load_data = '0;
    src_a     = '0;
    src_b     = '0;
    enable    = '0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #3;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_op_a", op_a, 32'd0);
    chk("reset_op_b", op_b, 32'd0);
    chk("reset_rd_count", 32'(rd_count), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    do_reset();

    // First accept right after reset release.
    rb[5] = 32'hDEADBEEF;
    rb[9] = 32'h12345678;
    src_a = 4'd5; src_b = 4'd9; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("first_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("first_op_a", op_a, 32'hDEADBEEF);
    chk("first_op_b", op_b, 32'h12345678);
    chk("first_rd_count", 32'(rd_count), 32'd1);

    // Backpressure: held response survives bank changes and ignored requests.
    rb[5] = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; src_a = 4'd1; src_b = 4'd2;
      #1;
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      tick();
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_op_a", op_a, 32'hDEADBEEF);
      chk("stall_op_b", op_b, 32'h12345678);
      chk("stall_rd_count", 32'(rd_count), 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

    // Back-to-back streaming from a fresh reset.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rb[i] = 32'hC0DE_0000 + 32'(i);
      rb[15 - i] = 32'h5EED_0000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; src_a = 4'(i); src_b = 4'(15 - i);
      #1;
      chk("stream_req_ready", 32'(req_ready), 32'd1);
      tick();
      chk("stream_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stream_op_a", op_a, 32'hC0DE_0000 + 32'(i));
      chk("stream_op_b", op_b, 32'h5EED_0000 + 32'(i));
    end
    req_valid = 1'b0;
    chk("stream_rd_count", 32'(rd_count), 32'd4);
    tick();
    chk("stream_idle_valid", 32'(rsp_valid), 32'd0);

    // Directed table: index extremes, equal sources, all-ones / all-zero data.
    tbl[0] = '{sa: 4'd0,  sb: 4'd15, va: 32'hFFFF_FFFF, vb: 32'h0000_0000};
    tbl[1] = '{sa: 4'd15, sb: 4'd0,  va: 32'h8000_0001, vb: 32'h7FFF_FFFE};
    tbl[2] = '{sa: 4'd7,  sb: 4'd7,  va: 32'hAAAA_5555, vb: 32'hAAAA_5555};
    tbl[3] = '{sa: 4'd1,  sb: 4'd14, va: 32'h0000_0001, vb: 32'hFFFF_FFFE};
    tbl[4] = '{sa: 4'd12, sb: 4'd12, va: 32'h1357_9BDF, vb: 32'h1357_9BDF};
    for (int i = 0; i < 5; i++) begin
      rb[tbl[i].sa] = tbl[i].va;
      rb[tbl[i].sb] = tbl[i].vb;
      src_a = tbl[i].sa; src_b = tbl[i].sb; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("table_op_a", op_a, tbl[i].va);
      chk("table_op_b", op_b, tbl[i].vb);
      tick();
    end
    chk("table_rd_count", 32'(rd_count), 32'd9);

    // Write forwarding: one-hot enable forwards, multi-hot does not.
    rsp_ready = 1'b1;
    rb[3] = 32'h0; rb[4] = 32'h4444_4444;
    enable = 16'h0008; load_data = 32'hA5A5A5A5;
    src_a = 4'd3; src_b = 4'd4; req_valid = 1'b1;
    tick();
`ifdef REG_READ_BYPASS_EN
    chk("bypass_onehot_op_a", op_a, 32'hA5A5A5A5);
`else
    chk("nobypass_op_a", op_a, 32'h0);
`endif
    chk("bypass_onehot_op_b", op_b, 32'h4444_4444);
    rb[3] = 32'h3333_3333;
    enable = 16'h0018;
    tick();
    req_valid = 1'b0;
    enable = '0;
    chk("bypass_multihot_op_a", op_a, 32'h3333_3333);
    chk("bypass_multihot_op_b", op_b, 32'h4444_4444);

    // Asynchronous reset in the middle of a held response.
    rsp_ready = 1'b0; req_valid = 1'b1; src_a = 4'd4;
    tick();
    req_valid = 1'b0;
    chk("prereset_rsp_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_op_a", op_a, 32'd0);
    chk("async_rd_count", 32'(rd_count), 32'd0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    chk("no_replay_rsp_valid", 32'(rsp_valid), 32'd0);

    // Counter wrap after 65535 accepts.
    req_valid = 1'b1; rsp_ready = 1'b1;
    repeat (65535) tick();
    chk("count_ffff", 32'(rd_count), 32'h0000_FFFF);
    tick();
    req_valid = 1'b0;
    chk("count_wrap", 32'(rd_count), 32'd0);

    // Randomized traffic against a one-slot scoreboard.
    do_reset();
    sb_q.delete();
    cnt = '0;
    for (int c = 0; c < 2000; c++) begin
      req_valid = 1'($urandom_range(0, 3) != 0);
      rsp_ready = 1'($urandom_range(0, 2) != 0);
      src_a = 4'($urandom);
      src_b = ($urandom_range(0, 5) == 0) ? src_a : 4'($urandom);
      if ($urandom_range(0, 3) == 0) rb[$urandom_range(0, 15)] = $urandom;
      case ($urandom_range(0, 3))
        0:       enable = '0;
        1, 2:    enable = 16'(1) << $urandom_range(0, 15);
        default: enable = 16'($urandom) | 16'h0101;
      endcase
      load_data = $urandom;
      #1;
      chk("rnd_req_ready", 32'(req_ready), 32'(sb_q.size() == 0 || rsp_ready));
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(sb_q.size() != 0));
      chk("rnd_rd_count", 32'(rd_count), 32'(cnt));
      if (sb_q.size() != 0) begin
        chk("rnd_op_a", op_a, sb_q[0].a);
        chk("rnd_op_b", op_b, sb_q[0].b);
      end
      acc = req_valid && (sb_q.size() == 0 || rsp_ready);
      if (sb_q.size() != 0 && rsp_ready) void'(sb_q.pop_front());
      if (acc) begin
        r.a = ref_op(src_a);
        r.b = ref_op(src_b);
        sb_q.push_back(r);
        cnt = cnt + 16'd1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
